if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the IF/ID stage: owns the PC and drives the word address into the synchronous instruction memory.
- Absorbs the memory's 1-cycle registered read latency.
- Presents {pc, instruction} to the IF/ID register with a valid/ready handshake.
- Handles branch/jump redirects from EX and holds the instruction while downstream is stalled.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (64 words).
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk_if  in  1  fetch clock, same clock as the instruction memory.
- rst_n  in  1  reset, asynchronous, active-low.
- im_addr  out  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2].
- im_inst  in  32  instruction memory registered read data: word at im_addr of the previous cycle.
- redirect_valid  in  1  EX requests a fetch redirect this cycle.
- redirect_pc  in  32  redirect target byte address.
- id_ready  in  1  IF/ID register accepts this cycle.
- id_valid  out  1  id_pc/id_inst are a valid fetched instruction.
- id_pc  out  32  byte address of the presented instruction.
- id_inst  out  32  presented instruction.
- id_misalign  out  1  present only with IF_MISALIGN_EN.

Behaviour:
- Clock and reset: one clock, clk_if. rst_n is asynchronous and active-low.
- Registers:
  - pc: address presented this cycle.
  - f_pc, f_valid: the fetch whose data is on im_inst this cycle.
  - hold_inst.
  - state ∈ {RUN, HOLD}.
- Reset (asynchronous, immediate):
  - pc=RESET_PC, f_valid=0, f_pc=0, hold_inst=0, state=RUN.
  - Outputs: id_valid=0, id_pc=0, id_inst=0, im_addr=RESET_PC[ADDR_W+1:2].
  - First valid output appears 2 cycles after rst_n deasserts: cycle 1 presents the address, cycle 2 returns the data.
- Output mux:
  - id_valid = f_valid && !redirect_valid.
  - id_pc = f_pc.
  - id_inst = (state==HOLD) ? hold_inst : im_inst.
  - id_pc and id_inst are forced to 0 when id_valid=0.
- Definitions:
  - accept = id_valid && id_ready.
  - advance = !f_valid || id_ready.
- RUN:
  - If advance: f_pc<=pc, f_valid<=1, pc<=pc+4.
  - If f_valid && !id_ready: hold_inst<=im_inst, state<=HOLD, pc and f_* unchanged. im_inst keeps re-reading pc, which is the next instruction.
- HOLD:
  - Output comes from hold_inst.
  - On id_ready: state<=RUN, f_pc<=pc, f_valid<=1, pc<=pc+4. im_inst already holds IM[pc], so there is no bubble.
  - Otherwise: all registers hold.
- Redirect (highest priority, any state):
  - id_valid is killed combinationally in the same cycle.
  - At the edge: pc<={redirect_pc[31:2],2'b00}, f_valid<=0, state<=RUN.
  - Target appears on id_* exactly 2 cycles after the redirect cycle. Penalty = 2 bubbles, including the killed cycle.
- Simultaneous redirect and id_ready: redirect wins. The killed instruction is not accepted.
- Simultaneous redirect and HOLD: the held instruction is discarded.
- Arithmetic:
  - pc+4 is 32-bit modulo 2^32.
  - im_addr truncates, so fetch wraps in memory: pc 0xFC → word 63, pc 0x100 → word 0. id_pc keeps full 32 bits.
- In-order, no duplicates: each fetched instruction is accepted exactly once.
- Reset mid-operation: any state or handshake is abandoned immediately with no partial update. Fetch restarts at RESET_PC.

Optional Feature:
- Macro: IF_MISALIGN_EN.
- Defined:
  - Port id_misalign exists.
  - Redirect with redirect_pc[1:0]!=0 sets a flag that travels with the target fetch. id_misalign=1 while that instruction is presented, including through HOLD, then clears on accept or on a later redirect.
  - Reset value 0.
  - The target is still fetched aligned.
- Undefined: port absent; low two bits are silently dropped.

Test Plan:
- Reset then id_ready=1, memory word n = 0x1000_0000+n, RESET_PC=0:
  - id_valid=0 in cycle 1.
  - Cycle 2 onward: id_pc 0,4,8… with id_inst 0x1000_0000, 0x1000_0001… one per cycle.
- Stall:
  - Hold id_ready=0 for 3 cycles while id_pc=0x8. id_pc=0x8 and id_inst=0x1000_0002 stay stable.
  - Then id_ready=1: next cycle id_pc=0xC, id_inst=0x1000_0003, no bubble, no duplicate.
- Redirect to 0x20 while id_pc=0x10 is valid:
  - id_valid=0 in that cycle and the next.
  - Then id_pc=0x20, id_inst=0x1000_0008, followed by 0x24.
- Redirect in HOLD with id_ready=1 in the same cycle:
  - Held instruction is never accepted.
  - Target appears 2 cycles later.
- Wrap: redirect to 0xF8 → id_pc 0xF8, 0xFC, 0x100 with im_addr 62, 63, 0 and id_inst word 62, 63, 0.
- rst_n pulled low mid-stall:
  - id_valid=0 immediately, before the next edge.
  - After release, fetch restarts at RESET_PC.
  - With IF_MISALIGN_EN, redirect 0x22 → id_pc=0x20, id_misalign=1 for that instruction only.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, hides the 1-cycle memory read latency, and hands {pc, inst} to IF/ID.
// Optional build macro IF_MISALIGN_EN adds id_misalign, which flags instructions reached by a misaligned redirect.
module if_fetch_unit #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_if,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_inst
`ifdef IF_MISALIGN_EN
    ,
    output logic              id_misalign
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] f_pc_r, f_pc_s;
    logic        f_valid_r, f_valid_s;
    logic [31:0] hold_inst_r, hold_inst_s;
    logic        advance_s;
    logic [31:0] pc_plus4_s;
    logic        fetch_s;

    assign advance_s  = !f_valid_r || id_ready;
    assign pc_plus4_s = pc_r + 32'd4;
    assign im_addr    = pc_r[ADDR_W+1:2];

    // Combinational presentation; a redirect kills the current output in the same cycle.
    always_comb begin
        id_valid = f_valid_r && !redirect_valid;
        if (id_valid) begin
            id_pc   = f_pc_r;
            id_inst = (state_r == HOLD) ? hold_inst_r : im_inst;
        end else begin
            id_pc   = 32'd0;
            id_inst = 32'd0;
        end
    end

    // Next-state logic; redirect overrides everything, including a pending accept.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        f_pc_s      = f_pc_r;
        f_valid_s   = f_valid_r;
        hold_inst_s = hold_inst_r;
        fetch_s     = 1'b0;
        if (redirect_valid) begin
            pc_s      = {redirect_pc[31:2], 2'b00};
            f_valid_s = 1'b0;
            state_s   = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (advance_s) begin
                        fetch_s = 1'b1;
                    end else begin
                        // Memory data is only valid this cycle; capture it before pc's word overwrites it.
                        hold_inst_s = im_inst;
                        state_s     = HOLD;
                    end
                end
                HOLD: begin
                    if (id_ready) begin
                        fetch_s = 1'b1;
                        state_s = RUN;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s   = RUN;
                    f_valid_s = 1'b0;
                end
            endcase
            if (fetch_s) begin
                f_pc_s    = pc_r;
                f_valid_s = 1'b1;
                pc_s      = pc_plus4_s;
            end else begin
                f_pc_s    = f_pc_s;
            end
        end
    end

    // Fetch pipeline state registers.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            pc_r        <= RESET_PC;
            f_pc_r      <= 32'd0;
            f_valid_r   <= 1'b0;
            hold_inst_r <= 32'd0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            f_pc_r      <= f_pc_s;
            f_valid_r   <= f_valid_s;
            hold_inst_r <= hold_inst_s;
        end
    end

`ifdef IF_MISALIGN_EN
    logic pend_mis_r, pend_mis_s;
    logic f_mis_r, f_mis_s;

    // pend_mis belongs to the address in pc; f_mis belongs to the fetch on im_inst.
    always_comb begin
        pend_mis_s = pend_mis_r;
        f_mis_s    = f_mis_r;
        if (redirect_valid) begin
            pend_mis_s = (redirect_pc[1:0] != 2'b00);
            f_mis_s    = 1'b0;
        end else if (fetch_s) begin
            f_mis_s    = pend_mis_r;
            pend_mis_s = 1'b0;
        end else begin
            pend_mis_s = pend_mis_r;
        end
    end

    // Misalignment flag registers.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            pend_mis_r <= 1'b0;
            f_mis_r    <= 1'b0;
        end else begin
            pend_mis_r <= pend_mis_s;
            f_mis_r    <= f_mis_s;
        end
    end

    assign id_misalign = id_valid && f_mis_r;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes expected accepts, a negedge monitor pops and compares them.
module tb_if_fetch_unit;

    localparam int ADDR_W = 6;

    logic              clk_if = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_inst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [31:0]       id_inst;
`ifdef IF_MISALIGN_EN
    logic              id_misalign;
`endif

    logic [31:0] mem [0:63];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    if_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk_if         (clk_if),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_inst        (im_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
`ifdef IF_MISALIGN_EN
        ,
        .id_misalign    (id_misalign)
`endif
    );

    always #5 clk_if = ~clk_if;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    end

    always @(posedge clk_if) im_inst <= mem[im_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(32'h1000_0000 + {26'd0, w[5:0]});
    endtask

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    // Monitor: every accepted transfer must match the next expected one, in order.
    always @(negedge clk_if) begin
        if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_pc_q.size() == 0) begin
                chk("unexpected_accept_pc", id_pc, 32'hFFFF_FFFF);
            end else begin
                chk("accept_pc", id_pc, exp_pc_q.pop_front());
                chk("accept_inst", id_inst, exp_inst_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        tick(); tick();
        chk("reset_valid", {31'd0, id_valid}, 32'd0);
        chk("reset_pc", id_pc, 32'd0);
        chk("reset_im_addr", {26'd0, im_addr}, 32'd0);
        rst_n = 1'b1;
        #1 chk("first_cycle_bubble", {31'd0, id_valid}, 32'd0);
        push(32'h0); push(32'h4);
        tick();
        chk("first_pc", id_pc, 32'h0);
        tick(); tick();
        // id_pc = 8: stall three cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", {31'd0, id_valid}, 32'd1);
            chk("stall_pc", id_pc, 32'h8);
            chk("stall_inst", id_inst, 32'h1000_0002);
            tick();
        end
        id_ready = 1'b1;
        push(32'h8); push(32'hC);
        tick();
        chk("no_bubble_pc", id_pc, 32'hC);
        chk("no_bubble_inst", id_inst, 32'h1000_0003);
        tick();
        chk("pre_redirect_pc", id_pc, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        #1 chk("redirect_kill", {31'd0, id_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1 chk("redirect_bubble", {31'd0, id_valid}, 32'd0);
        push(32'h20); push(32'h24);
        tick();
        chk("redirect_target_pc", id_pc, 32'h20);
        chk("redirect_target_inst", id_inst, 32'h1000_0008);
        tick();
        tick();
        // id_pc = 0x28: stall into HOLD, then redirect with id_ready high
        id_ready = 1'b0;
        tick();
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hF8;
        #1 chk("hold_redirect_kill", {31'd0, id_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1 chk("hold_redirect_bubble", {31'd0, id_valid}, 32'd0);
        chk("wrap_im_addr_62", {26'd0, im_addr}, 32'd62);
        push(32'hF8); push(32'hFC); push(32'h100);
        tick();
        chk("wrap_pc_f8", id_pc, 32'hF8);
        chk("wrap_im_addr_63", {26'd0, im_addr}, 32'd63);
        tick();
        chk("wrap_im_addr_0", {26'd0, im_addr}, 32'd0);
        tick();
        chk("wrap_pc_100", id_pc, 32'h100);
        chk("wrap_inst_0", id_inst, 32'h1000_0000);
        tick();
        // id_pc = 0x104: stall, then reset mid-stall
        id_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1 chk("async_reset_valid", {31'd0, id_valid}, 32'd0);
        chk("async_reset_im_addr", {26'd0, im_addr}, 32'd0);
        tick();
        id_ready = 1'b1;
        rst_n = 1'b1;
        #1 chk("restart_bubble", {31'd0, id_valid}, 32'd0);
        push(32'h0); push(32'h4); push(32'h8);
        tick();
        chk("restart_pc", id_pc, 32'h0);
        tick(); tick(); tick();
        // id_pc = 0xC: misaligned redirect, low bits dropped from the fetch address
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        #1 chk("mis_redirect_kill", {31'd0, id_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        push(32'h20); push(32'h24);
        tick();
        chk("mis_target_pc", id_pc, 32'h20);
`ifdef IF_MISALIGN_EN
        chk("mis_flag_set", {31'd0, id_misalign}, 32'd1);
`endif
        tick();
        chk("mis_next_pc", id_pc, 32'h24);
`ifdef IF_MISALIGN_EN
        chk("mis_flag_clear", {31'd0, id_misalign}, 32'd0);
`endif
        tick();
        id_ready = 1'b0;
        tick(); tick();
        chk("scoreboard_drained", exp_pc_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
